// File: rtl/sram_request_arbiter.sv
// Two-port round-robin arbiter that shares one memory-block port between instruction fetch (port 0) and data (port 1).
// Optional watchdog: define SRAM_ARB_TIMEOUT_EN to force completion with err after TIMEOUT_CYCLES stalled cycles.
module sram_request_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              req0,
    input  logic              wen0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [3:0]        byte_en0,
    output logic [DATA_W-1:0] rdata0,
    output logic              wait0,
    output logic              err0,
    input  logic              req1,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [3:0]        byte_en1,
    output logic [DATA_W-1:0] rdata1,
    output logic              wait1,
    output logic              err1,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_byte_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wait,
    output logic              grant_id,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t r_state, w_state_next;
    logic   r_owner, w_owner_next;
    logic   r_last_grant, w_last_grant_next;

    logic              w_owner_req;
    logic              w_other_req;
    logic              w_active;
    logic              w_forced;
    logic              w_complete;
    logic              w_done0;
    logic              w_done1;
    logic [DATA_W-1:0] w_resp_data;

    assign w_owner_req = r_owner ? req1 : req0;
    assign w_other_req = r_owner ? req0 : req1;
    // An owner that withdrew its request mid-access gets no memory cycle.
    assign w_active    = (r_state == S_BUSY) && w_owner_req;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hBAD1BAD1);

    logic [CNT_W-1:0] r_tcnt, w_tcnt_next;

    assign w_forced    = w_active && mem_wait && (r_tcnt == CNT_W'(TIMEOUT_CYCLES));
    assign w_resp_data = w_forced ? ERR_DATA : mem_rdata;

    // Any cycle that is not a plain stall (completion, handoff, idle) restarts the count.
    always_comb begin
        w_tcnt_next = '0;
        if (w_active && mem_wait && !w_forced)
            w_tcnt_next = r_tcnt + 1'b1;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            r_tcnt <= '0;
        else
            r_tcnt <= w_tcnt_next;
    end
`else
    assign w_forced    = 1'b0;
    assign w_resp_data = mem_rdata;
`endif

    assign w_complete = w_active && (!mem_wait || w_forced);
    assign w_done0    = w_complete && !r_owner;
    assign w_done1    = w_complete && r_owner;

    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_grant_next = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state_next      = S_BUSY;
                    w_owner_next      = (req0 && req1) ? ~r_last_grant : req1;
                    w_last_grant_next = (req0 && req1) ? ~r_last_grant : req1;
                end
            end
            S_BUSY: begin
                if (!w_owner_req) begin
                    w_state_next = S_IDLE;
                end else if (w_complete) begin
                    if (w_other_req) begin
                        w_owner_next      = ~r_owner;
                        w_last_grant_next = ~r_owner;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    assign mem_en      = w_active;
    assign mem_wen     = w_active && (r_owner ? wen1 : wen0);
    assign mem_addr    = w_active ? (r_owner ? addr1 : addr0) : '0;
    assign mem_wdata   = w_active ? (r_owner ? wdata1 : wdata0) : '0;
    assign mem_byte_en = w_active ? (r_owner ? byte_en1 : byte_en0) : 4'b0000;

    assign wait0  = req0 && !w_done0;
    assign wait1  = req1 && !w_done1;
    assign rdata0 = w_done0 ? w_resp_data : '0;
    assign rdata1 = w_done1 ? w_resp_data : '0;
    assign err0   = w_forced && !r_owner;
    assign err1   = w_forced && r_owner;

    assign grant_id = r_owner;
    assign busy     = (r_state == S_BUSY);

endmodule

// File: tb/tb_sram_request_arbiter.sv
// Directed vector bench for sram_request_arbiter: cycle table plus hand sequences for reset, fairness and timeout.
module tb_sram_request_arbiter;

    localparam bit L = 1'b0;
    localparam bit H = 1'b1;

    localparam logic [31:0] A0 = 32'h0000_8000;
    localparam logic [31:0] D0 = 32'h0BAD_F00D;
    localparam logic [3:0]  B0 = 4'b0011;
    localparam logic [31:0] A1 = 32'h0000_0004;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [3:0]  B1 = 4'b1111;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        req0 = 1'b0, wen0 = 1'b0, req1 = 1'b0, wen1 = 1'b1;
    logic [31:0] addr0 = A0, wdata0 = D0, addr1 = A1, wdata1 = D1;
    logic [3:0]  byte_en0 = B0, byte_en1 = B1;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        wait0, wait1, err0, err1, mem_en, mem_wen, grant_id, busy;
    logic [3:0]  mem_byte_en;
    logic        mem_wait = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .nRST(nRST),
        .req0(req0), .wen0(wen0), .addr0(addr0), .wdata0(wdata0), .byte_en0(byte_en0),
        .rdata0(rdata0), .wait0(wait0), .err0(err0),
        .req1(req1), .wen1(wen1), .addr1(addr1), .wdata1(wdata1), .byte_en1(byte_en1),
        .rdata1(rdata1), .wait1(wait1), .err1(err1),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata), .mem_wait(mem_wait),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        bit          rstn;
        bit          r0;
        bit          r1;
        logic [31:0] md;
        bit          mw;
        bit          en;
        bit          mport;
        bit          w0;
        bit          w1;
        logic [31:0] rd0;
        logic [31:0] rd1;
        bit          bsy;
        bit          gid;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(bit rstn, bit r0, bit r1, logic [31:0] md, bit mw,
                                bit en, bit mport, bit w0, bit w1,
                                logic [31:0] rd0, logic [31:0] rd1, bit bsy, bit gid);
        vec_t v;
        v.rstn = rstn; v.r0 = r0; v.r1 = r1; v.md = md; v.mw = mw;
        v.en = en; v.mport = mport; v.w0 = w0; v.w1 = w1;
        v.rd0 = rd0; v.rd1 = rd1; v.bsy = bsy; v.gid = gid;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        //            rstn r0 r1 mem_rdata     mw   en mp w0 w1 rdata0        rdata1        busy gid
        vecs[0]  = mk(L, L, L, 32'h0,         L,   L, L, L, L, 32'h0,         32'h0,        L, L);
        vecs[1]  = mk(H, H, H, 32'hA5A5A5A5,  L,   L, L, H, H, 32'h0,         32'h0,        L, L);
        vecs[2]  = mk(H, H, H, 32'hA5A5A5A5,  L,   H, L, L, H, 32'hA5A5A5A5,  32'h0,        H, L);
        vecs[3]  = mk(H, L, H, 32'h5A5A5A5A,  L,   H, H, L, L, 32'h0,         32'h5A5A5A5A, H, H);
        vecs[4]  = mk(H, L, L, 32'h0,         L,   L, L, L, L, 32'h0,         32'h0,        L, H);
        vecs[5]  = mk(H, H, L, 32'h12345678,  L,   L, L, H, L, 32'h0,         32'h0,        L, H);
        vecs[6]  = mk(H, H, L, 32'h12345678,  L,   H, L, L, L, 32'h12345678,  32'h0,        H, L);
        vecs[7]  = mk(H, L, L, 32'h0,         L,   L, L, L, L, 32'h0,         32'h0,        L, L);
        vecs[8]  = mk(H, L, H, 32'h0,         H,   L, L, L, H, 32'h0,         32'h0,        L, L);
        vecs[9]  = mk(H, H, H, 32'hFFFF0000,  H,   H, H, H, H, 32'h0,         32'h0,        H, H);
        vecs[10] = mk(H, H, H, 32'hFFFF0000,  H,   H, H, H, H, 32'h0,         32'h0,        H, H);
        vecs[11] = mk(H, H, H, 32'hFFFF0000,  H,   H, H, H, H, 32'h0,         32'h0,        H, H);
        vecs[12] = mk(H, H, H, 32'h11112222,  L,   H, H, H, L, 32'h0,         32'h11112222, H, H);
        vecs[13] = mk(H, H, L, 32'h33334444,  L,   H, L, L, L, 32'h33334444,  32'h0,        H, L);
        vecs[14] = mk(H, L, L, 32'h0,         L,   L, L, L, L, 32'h0,         32'h0,        L, L);
        vecs[15] = mk(H, H, L, 32'h0,         H,   L, L, H, L, 32'h0,         32'h0,        L, L);
        vecs[16] = mk(H, H, L, 32'h0,         H,   H, L, H, L, 32'h0,         32'h0,        H, L);
        vecs[17] = mk(H, L, L, 32'h0,         H,   L, L, L, L, 32'h0,         32'h0,        H, L);
        vecs[18] = mk(H, L, L, 32'h0,         L,   L, L, L, L, 32'h0,         32'h0,        L, L);
        vecs[19] = mk(H, H, L, 32'h77778888,  L,   L, L, H, L, 32'h0,         32'h0,        L, L);
        vecs[20] = mk(H, H, L, 32'h77778888,  L,   H, L, L, L, 32'h77778888,  32'h0,        H, L);
        vecs[21] = mk(H, H, L, 32'h77778888,  L,   L, L, H, L, 32'h0,         32'h0,        L, L);
        vecs[22] = mk(H, H, L, 32'h77778888,  L,   H, L, L, L, 32'h77778888,  32'h0,        H, L);
        vecs[23] = mk(H, L, L, 32'h0,         L,   L, L, L, L, 32'h0,         32'h0,        L, L);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            nRST      = vecs[i].rstn;
            req0      = vecs[i].r0;
            req1      = vecs[i].r1;
            mem_rdata = vecs[i].md;
            mem_wait  = vecs[i].mw;
            #1;
            chk1 ("mem_en",      mem_en,      vecs[i].en);
            chk1 ("mem_wen",     mem_wen,     vecs[i].en & vecs[i].mport);
            chk32("mem_addr",    mem_addr,    vecs[i].en ? (vecs[i].mport ? A1 : A0) : 32'h0);
            chk32("mem_wdata",   mem_wdata,   vecs[i].en ? (vecs[i].mport ? D1 : D0) : 32'h0);
            chk32("mem_byte_en", {28'h0, mem_byte_en}, {28'h0, vecs[i].en ? (vecs[i].mport ? B1 : B0) : 4'h0});
            chk1 ("wait0",       wait0,       vecs[i].w0);
            chk1 ("wait1",       wait1,       vecs[i].w1);
            chk32("rdata0",      rdata0,      vecs[i].rd0);
            chk32("rdata1",      rdata1,      vecs[i].rd1);
            chk1 ("busy",        busy,        vecs[i].bsy);
            chk1 ("grant_id",    grant_id,    vecs[i].gid);
            chk1 ("err0",        err0,        L);
            chk1 ("err1",        err1,        L);
            $display("vec %0d: req=%b%b en=%b addr=%h wait=%b%b rdata0=%h rdata1=%h busy=%b gid=%b",
                     i, req0, req1, mem_en, mem_addr, wait0, wait1, rdata0, rdata1, busy, grant_id);
        end

        // Reset dropped while port 1 is stalled mid-access.
        @(negedge clk);
        req0 = L; req1 = H; mem_wait = H;
        @(negedge clk);
        #1;
        chk1("rst_pre_busy", busy, H);
        chk1("rst_pre_gid", grant_id, H);
        nRST = L;
        req0 = H;
        #1;
        chk1("rst_mem_en", mem_en, L);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk1("rst_busy", busy, L);
        chk1("rst_wait0", wait0, H);
        chk1("rst_wait1", wait1, H);
        chk1("rst_gid", grant_id, L);
        $display("reset mid-op: en=%b busy=%b wait=%b%b", mem_en, busy, wait0, wait1);

        // Release with both requesting: port 0 first, then strict alternation.
        @(negedge clk);
        nRST = H; mem_wait = L; mem_rdata = 32'hC0DE0000;
        #1;
        chk1("rel_busy", busy, L);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            mem_rdata = 32'hC0DE0000 + 32'(k);
            #1;
            chk1("rr_mem_en", mem_en, H);
            chk1("rr_gid", grant_id, k[0]);
            chk1("rr_wait0", wait0, k[0]);
            chk1("rr_wait1", wait1, ~k[0]);
            chk32("rr_rdata", k[0] ? rdata1 : rdata0, 32'hC0DE0000 + 32'(k));
            $display("rr txn %0d: gid=%b wait=%b%b", k, grant_id, wait0, wait1);
        end
        @(negedge clk);
        req0 = L; req1 = L;
        @(negedge clk);
        #1;
        chk1("rr_end_busy", busy, L);

`ifdef SRAM_ARB_TIMEOUT_EN
        // Port 0 read with memory stuck in wait: forced completion on 5th busy cycle.
        @(negedge clk);
        req0 = H; mem_wait = H; mem_rdata = 32'h12345678;
        #1;
        chk1("to_idle_busy", busy, L);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            #1;
            chk1("to_mem_en", mem_en, H);
            chk1("to_err0", err0, (c == 5));
            chk1("to_err1", err1, L);
            chk1("to_wait0", wait0, (c != 5));
            chk32("to_rdata0", rdata0, (c == 5) ? 32'hBAD1BAD1 : 32'h0);
            $display("timeout cycle %0d: err0=%b wait0=%b rdata0=%h", c, err0, wait0, rdata0);
        end
        @(negedge clk);
        req0 = L;
        #1;
        chk1("to_after_busy", busy, L);
        chk1("to_after_err0", err0, L);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
